dataline_burst_array: RTL and testbench

Parametrised cache data array, successor to the single-port byte/half/word data store. Adds configurable associativity and line length, a registered CPU read path with signed/unsigned sub-word loads, and two burst engines: a line-fill port accepting a whole line from memory over valid/ready, and an evict port streaming a whole line out for writeback. Sits between the cache controller (which owns tags and decides set and way) and the memory interface.

---
 rtl/dataline_burst_array.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dataline_burst_array.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataline_burst_array.sv
// dataline_burst_array
//
// Cache data array with configurable associativity and line length. The cache
// controller owns the tags and picks set/way; this block only stores data.
//
// Three users share the array:
//   - CPU port   : byte/half/word stores and loads. Stores only happen in IDLE.
//                  Loads return a registered result one cycle after acceptance.
//   - Fill port  : accepts a whole line from memory, one beat per fill_valid.
//   - Evict port : streams a whole line out for writeback over valid/ready.
//
// Ports
//   clk, reset                         clock, asynchronous active-high reset
//   cpu_req/cpu_ready/cpu_write        CPU request handshake and direction
//   set/selected_way/word_select       CPU line and word address
//   byte_select/op_size/load_signed    sub-word selection and load extension
//   word_to_store                      store data, low-aligned
//   fetched_word/fetched_valid         registered load result and its pulse
//   fill_start/fill_set/fill_way       line fill request
//   fill_valid/fill_ready/fill_data    fill beat handshake
//   fill_done                          pulse after the final fill beat
//   evict_start/evict_set/evict_way    line evict request
//   evict_valid/evict_ready/evict_data/evict_last  evict beat handshake
//   busy                               a burst is in progress

package dataline_burst_array_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memory_operation_size_e;
endpackage

module dataline_burst_array
    import dataline_burst_array_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int NUM_SETS         = 4,
    parameter int ASSOC            = 2,
    parameter int WORDS_PER_LINE   = 8,
    parameter int SET_SIZE         = $clog2(NUM_SETS),
    parameter int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE),
    parameter int ASSOC_WIDTH      = (ASSOC > 1) ? $clog2(ASSOC) : 1,
    parameter int BYTE_SELECT_SIZE = $clog2(XLEN / 8)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req,
    output logic                        cpu_ready,
    input  logic                        cpu_write,
    input  logic [SET_SIZE-1:0]         set,
    input  logic [ASSOC_WIDTH-1:0]      selected_way,
    input  logic [WORD_SELECT_SIZE-1:0] word_select,
    input  logic [BYTE_SELECT_SIZE-1:0] byte_select,
    input  memory_operation_size_e      op_size,
    input  logic                        load_signed,
    input  logic [XLEN-1:0]             word_to_store,
    output logic [XLEN-1:0]             fetched_word,
    output logic                        fetched_valid,
    input  logic                        fill_start,
    input  logic                        evict_start,
    input  logic [SET_SIZE-1:0]         fill_set,
    input  logic [SET_SIZE-1:0]         evict_set,
    input  logic [ASSOC_WIDTH-1:0]      fill_way,
    input  logic [ASSOC_WIDTH-1:0]      evict_way,
    input  logic                        fill_valid,
    output logic                        fill_ready,
    input  logic [XLEN-1:0]             fill_data,
    output logic                        fill_done,
    output logic                        evict_valid,
    input  logic                        evict_ready,
    output logic [XLEN-1:0]             evict_data,
    output logic                        evict_last,
    output logic                        busy
);

    localparam int NUM_BYTES = XLEN / 8;
    localparam int DEPTH     = NUM_SETS * ASSOC * WORDS_PER_LINE;
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_SELECT_SIZE-1:0] LAST_WORD = WORD_SELECT_SIZE'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        EVICT = 2'b10
    } state_e;

    // Flat word index; arithmetic rather than concatenation so ASSOC need
    // not be a power of two.
    function automatic logic [ADDR_W-1:0] word_index(
        input logic [SET_SIZE-1:0]         s,
        input logic [ASSOC_WIDTH-1:0]      w,
        input logic [WORD_SELECT_SIZE-1:0] wd
    );
        return ADDR_W'((32'(s) * 32'(ASSOC) + 32'(w)) * 32'(WORDS_PER_LINE) + 32'(wd));
    endfunction

    logic [XLEN-1:0]             mem_q [DEPTH];

    state_e                      state_q, state_d;
    logic [WORD_SELECT_SIZE-1:0] count_q, count_d;
    logic [SET_SIZE-1:0]         line_set_q, line_set_d;
    logic [ASSOC_WIDTH-1:0]      line_way_q, line_way_d;
    logic [XLEN-1:0]             fetched_word_q, fetched_word_d;
    logic                        fetched_valid_q, fetched_valid_d;
    logic                        fill_done_q, fill_done_d;

    logic [ADDR_W-1:0]           cpu_addr_s;
    logic [ADDR_W-1:0]           line_addr_s;
    logic [XLEN-1:0]             cpu_rdata_s;
    logic [7:0]                  rd_byte_s;
    logic [15:0]                 rd_half_s;
    logic [XLEN-1:0]             load_data_s;
    logic [XLEN-1:0]             store_data_s;
    logic [NUM_BYTES-1:0]        store_be_s;
    logic                        store_valid_s;

    logic                        mem_we_s;
    logic [ADDR_W-1:0]           mem_addr_s;
    logic [NUM_BYTES-1:0]        mem_be_s;
    logic [XLEN-1:0]             mem_wdata_s;

    assign cpu_addr_s  = word_index(set, selected_way, word_select);
    assign line_addr_s = word_index(line_set_q, line_way_q, count_q);
    assign cpu_rdata_s = mem_q[cpu_addr_s];
    assign rd_byte_s   = cpu_rdata_s[{byte_select, 3'b000} +: 8];
    // Halfword loads ignore the low byte_select bit (unaligned bits dropped).
    assign rd_half_s   = cpu_rdata_s[{byte_select[BYTE_SELECT_SIZE-1:1], 4'b0000} +: 16];

    // Sub-word lane selection for stores and extension for loads.
    always_comb begin
        store_valid_s = 1'b1;
        store_be_s    = {NUM_BYTES{1'b0}};
        store_data_s  = word_to_store;
        load_data_s   = cpu_rdata_s;
        case (op_size)
            BYTE: begin
                store_be_s   = NUM_BYTES'(1'b1) << byte_select;
                store_data_s = {NUM_BYTES{word_to_store[7:0]}};
                load_data_s  = {{(XLEN-8){load_signed & rd_byte_s[7]}}, rd_byte_s};
            end
            HALF: begin
                store_be_s   = NUM_BYTES'(2'b11) << {byte_select[BYTE_SELECT_SIZE-1:1], 1'b0};
                store_data_s = {(NUM_BYTES/2){word_to_store[15:0]}};
                load_data_s  = {{(XLEN-16){load_signed & rd_half_s[15]}}, rd_half_s};
            end
            WORD: begin
                store_be_s   = {NUM_BYTES{1'b1}};
                store_data_s = word_to_store;
                load_data_s  = cpu_rdata_s;
            end
            default: begin
                store_valid_s = 1'b0;
                load_data_s   = {XLEN{1'bx}};
            end
        endcase
    end

    // Next-state logic, burst counter, array write port and registered outputs.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        line_set_d      = line_set_q;
        line_way_d      = line_way_q;
        fetched_word_d  = fetched_word_q;
        fetched_valid_d = 1'b0;
        fill_done_d     = 1'b0;
        mem_we_s        = 1'b0;
        mem_addr_s      = cpu_addr_s;
        mem_be_s        = store_be_s;
        mem_wdata_s     = store_data_s;
        case (state_q)
            IDLE: begin
                // Evict has priority; a colliding fill_start is dropped and the
                // controller re-issues it. Any start also blocks the CPU.
                if (evict_start) begin
                    state_d    = EVICT;
                    line_set_d = evict_set;
                    line_way_d = evict_way;
                    count_d    = {WORD_SELECT_SIZE{1'b0}};
                end else if (fill_start) begin
                    state_d    = FILL;
                    line_set_d = fill_set;
                    line_way_d = fill_way;
                    count_d    = {WORD_SELECT_SIZE{1'b0}};
                end else if (cpu_req) begin
                    if (cpu_write) begin
                        mem_we_s = store_valid_s;
                    end else begin
                        fetched_valid_d = 1'b1;
                        fetched_word_d  = load_data_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (fill_valid) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = line_addr_s;
                    mem_be_s    = {NUM_BYTES{1'b1}};
                    mem_wdata_s = fill_data;
                    if (count_q == LAST_WORD) begin
                        state_d     = IDLE;
                        count_d     = {WORD_SELECT_SIZE{1'b0}};
                        fill_done_d = 1'b1;
                    end else begin
                        count_d = count_q + WORD_SELECT_SIZE'(1'b1);
                    end
                end else begin
                    count_d = count_q;
                end
            end
            EVICT: begin
                // evict_data follows count_q, so holding the count holds the data.
                if (evict_ready) begin
                    if (count_q == LAST_WORD) begin
                        state_d = IDLE;
                        count_d = {WORD_SELECT_SIZE{1'b0}};
                    end else begin
                        count_d = count_q + WORD_SELECT_SIZE'(1'b1);
                    end
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = {WORD_SELECT_SIZE{1'b0}};
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            count_q         <= {WORD_SELECT_SIZE{1'b0}};
            line_set_q      <= {SET_SIZE{1'b0}};
            line_way_q      <= {ASSOC_WIDTH{1'b0}};
            fetched_word_q  <= {XLEN{1'b0}};
            fetched_valid_q <= 1'b0;
            fill_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            line_set_q      <= line_set_d;
            line_way_q      <= line_way_d;
            fetched_word_q  <= fetched_word_d;
            fetched_valid_q <= fetched_valid_d;
            fill_done_q     <= fill_done_d;
        end
    end

    // Data storage with byte-lane write enables; intentionally not reset so a
    // reset mid-fill keeps the beats already written.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (mem_be_s[b]) begin
                    mem_q[mem_addr_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
                end
            end
        end
    end

    assign cpu_ready     = (state_q == IDLE) && !fill_start && !evict_start;
    assign fetched_word  = fetched_word_q;
    assign fetched_valid = fetched_valid_q;
    assign fill_ready    = (state_q == FILL);
    assign fill_done     = fill_done_q;
    assign evict_valid   = (state_q == EVICT);
    assign evict_data    = evict_valid ? mem_q[line_addr_s] : {XLEN{1'b0}};
    assign evict_last    = evict_valid && (count_q == LAST_WORD);
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dataline_burst_array.sv
// Self-checking bench for dataline_burst_array. A byte-addressed reference
// model of the whole array predicts every load and evict beat.
module tb_dataline_burst_array;
    import dataline_burst_array_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_ready, cpu_write;
    logic [1:0]  set;
    logic [0:0]  selected_way;
    logic [2:0]  word_select;
    logic [1:0]  byte_select;
    memory_operation_size_e op_size;
    logic        load_signed;
    logic [31:0] word_to_store, fetched_word;
    logic        fetched_valid;
    logic        fill_start, evict_start;
    logic [1:0]  fill_set, evict_set;
    logic [0:0]  fill_way, evict_way;
    logic        fill_valid, fill_ready, fill_done;
    logic [31:0] fill_data, evict_data;
    logic        evict_valid, evict_ready, evict_last, busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mb [256];

    always #5 clk = ~clk;

    dataline_burst_array dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_ready(cpu_ready),
        .cpu_write(cpu_write), .set(set), .selected_way(selected_way),
        .word_select(word_select), .byte_select(byte_select), .op_size(op_size),
        .load_signed(load_signed), .word_to_store(word_to_store),
        .fetched_word(fetched_word), .fetched_valid(fetched_valid),
        .fill_start(fill_start), .evict_start(evict_start),
        .fill_set(fill_set), .evict_set(evict_set), .fill_way(fill_way),
        .evict_way(evict_way), .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_data(fill_data), .fill_done(fill_done), .evict_valid(evict_valid),
        .evict_ready(evict_ready), .evict_data(evict_data), .evict_last(evict_last),
        .busy(busy)
    );

    // ---------------- reference model ----------------
    function automatic int base_of(int s, int w, int wd);
        return ((s * 2 + w) * 8 + wd) * 4;
    endfunction

    function automatic void model_store(int s, int w, int wd, int bs,
                                        memory_operation_size_e op, logic [31:0] d);
        int b = base_of(s, w, wd);
        int h = b + (bs & 2);
        case (op)
            BYTE: mb[b + bs] = d[7:0];
            HALF: begin mb[h] = d[7:0]; mb[h + 1] = d[15:8]; end
            WORD: begin
                mb[b] = d[7:0]; mb[b + 1] = d[15:8];
                mb[b + 2] = d[23:16]; mb[b + 3] = d[31:24];
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_word(int s, int w, int wd);
        int b = base_of(s, w, wd);
        return {mb[b + 3], mb[b + 2], mb[b + 1], mb[b]};
    endfunction

    function automatic logic [31:0] model_load(int s, int w, int wd, int bs,
                                               memory_operation_size_e op, logic sgn);
        int b = base_of(s, w, wd);
        int h = b + (bs & 2);
        logic [31:0] r;
        case (op)
            BYTE: begin
                r = {24'h0, mb[b + bs]};
                if (sgn && mb[b + bs][7]) r = r | 32'hFFFF_FF00;
            end
            HALF: begin
                r = {16'h0, mb[h + 1], mb[h]};
                if (sgn && mb[h + 1][7]) r = r | 32'hFFFF_0000;
            end
            default: r = model_word(s, w, wd);
        endcase
        return r;
    endfunction

    // ---------------- drivers (called just after a falling edge) ----------------
    task automatic do_cpu(input logic wr, input int s, input int w, input int wd, input int bs,
                          input memory_operation_size_e op, input logic sgn, input logic [31:0] d,
                          output logic [31:0] fw, output logic fv);
        cpu_req = 1'b1; cpu_write = wr; set = 2'(s); selected_way = 1'(w);
        word_select = 3'(wd); byte_select = 2'(bs); op_size = op;
        load_signed = sgn; word_to_store = d;
        @(negedge clk);
        cpu_req = 1'b0; cpu_write = 1'b0;
        fw = fetched_word; fv = fetched_valid;
    endtask

    task automatic fill_line(input int s, input int w, input logic [31:0] d [8], input int sk [8],
                             output int ready_cycles, output int done_pulses,
                             output logic done_first, output logic cpu_ready_first);
        ready_cycles = 0; done_pulses = 0;
        fill_start = 1'b1; fill_set = 2'(s); fill_way = 1'(w);
        @(negedge clk);
        fill_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < sk[i]; k++) begin
                fill_valid = 1'b0; #1;
                if (fill_ready) ready_cycles++;
                if (fill_done) done_pulses++;
                @(negedge clk);
            end
            fill_valid = 1'b1; fill_data = d[i]; #1;
            if (fill_ready) ready_cycles++;
            if (fill_done) done_pulses++;
            @(negedge clk);
        end
        fill_valid = 1'b0; fill_data = 32'h0;
        done_first = fill_done; cpu_ready_first = cpu_ready;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (fill_ready) ready_cycles++;
            if (fill_done) done_pulses++;
            @(negedge clk);
        end
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,1,0...; mode 2: random
    task automatic evict_line(input int s, input int w, input int mode, output logic [31:0] got [8],
                              output int stable_err, output int last_err, output int cycles,
                              output logic timed_out);
        int n = 0;
        logic stalled = 1'b0;
        logic rdy;
        logic [31:0] prev = 32'h0;
        stable_err = 0; last_err = 0; cycles = 0;
        for (int i = 0; i < 8; i++) got[i] = 32'h0;
        evict_start = 1'b1; evict_set = 2'(s); evict_way = 1'(w);
        @(negedge clk);
        evict_start = 1'b0;
        while (n < 8 && cycles < 64) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cycles % 2 == 0);
            else rdy = 1'($urandom_range(0, 1));
            evict_ready = rdy; #1;
            if (evict_valid) begin
                if (stalled && evict_data !== prev) stable_err++;
                if (evict_last !== (n == 7)) last_err++;
                if (rdy) begin got[n] = evict_data; n++; end
                stalled = !rdy; prev = evict_data;
            end else begin
                stalled = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        evict_ready = 1'b0;
        timed_out = (n < 8);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 0; cpu_write = 0; set = 0; selected_way = 0; word_select = 0;
        byte_select = 0; op_size = WORD; load_signed = 0; word_to_store = 0;
        fill_start = 0; evict_start = 0; fill_set = 0; evict_set = 0; fill_way = 0;
        evict_way = 0; fill_valid = 0; fill_data = 0; evict_ready = 0;
        repeat (2) @(negedge clk);
        tests_run++; if (cpu_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cpu_ready got %b want 1", cpu_ready); end
        tests_run++; if (fetched_word !== 32'h0) begin tests_failed++; $display("FAIL reset_fetched_word got %h want 0", fetched_word); end
        tests_run++; if (fetched_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_fetched_valid got %b want 0", fetched_valid); end
        tests_run++; if (fill_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_fill_ready got %b want 0", fill_ready); end
        tests_run++; if (fill_done !== 1'b0) begin tests_failed++; $display("FAIL reset_fill_done got %b want 0", fill_done); end
        tests_run++; if (evict_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_evict_valid got %b want 0", evict_valid); end
        tests_run++; if (evict_data !== 32'h0) begin tests_failed++; $display("FAIL reset_evict_data got %h want 0", evict_data); end
        tests_run++; if (evict_last !== 1'b0) begin tests_failed++; $display("FAIL reset_evict_last got %b want 0", evict_last); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_init_array();
        logic [31:0] fw, d;
        logic fv;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            do_cpu(1'b1, i / 16, (i / 8) % 2, i % 8, 0, WORD, 1'b0, d, fw, fv);
            model_store(i / 16, (i / 8) % 2, i % 8, 0, WORD, d);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] fw;
        logic fv;
        do_cpu(1'b1, 1, 1, 3, 0, WORD, 1'b0, 32'hDEADBEEF, fw, fv);
        model_store(1, 1, 3, 0, WORD, 32'hDEADBEEF);
        tests_run++; if (fv !== 1'b0) begin tests_failed++; $display("FAIL store_no_valid got %b want 0", fv); end
        do_cpu(1'b0, 1, 1, 3, 0, WORD, 1'b0, 32'h0, fw, fv);
        tests_run++; if (fw !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL word_load got %h want deadbeef", fw); end
        tests_run++; if (fv !== 1'b1) begin tests_failed++; $display("FAIL word_load_valid got %b want 1", fv); end
        @(negedge clk);
        tests_run++; if (fetched_valid !== 1'b0) begin tests_failed++; $display("FAIL valid_pulse got %b want 0", fetched_valid); end
        do_cpu(1'b1, 1, 1, 3, 2, BYTE, 1'b0, 32'h0000_0080, fw, fv);
        model_store(1, 1, 3, 2, BYTE, 32'h0000_0080);
        do_cpu(1'b0, 1, 1, 3, 2, BYTE, 1'b1, 32'h0, fw, fv);
        tests_run++; if (fw !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL byte_signed got %h want ffffff80", fw); end
        do_cpu(1'b0, 1, 1, 3, 2, BYTE, 1'b0, 32'h0, fw, fv);
        tests_run++; if (fw !== 32'h00000080) begin tests_failed++; $display("FAIL byte_unsigned got %h want 00000080", fw); end
        // Word is now DE80BEEF; halfword at bytes 3:2 is DE80.
        do_cpu(1'b0, 1, 1, 3, 2, HALF, 1'b1, 32'h0, fw, fv);
        tests_run++; if (fw !== 32'hFFFFDE80) begin tests_failed++; $display("FAIL half_signed got %h want ffffde80", fw); end
        do_cpu(1'b0, 1, 1, 3, 3, HALF, 1'b0, 32'h0, fw, fv);
        tests_run++; if (fw !== 32'h0000DE80) begin tests_failed++; $display("FAIL half_unaligned got %h want 0000de80", fw); end
        do_cpu(1'b0, 1, 1, 3, 1, WORD, 1'b1, 32'h0, fw, fv);
        tests_run++; if (fw !== 32'hDE80BEEF) begin tests_failed++; $display("FAIL word_after_byte got %h want de80beef", fw); end
        do_cpu(1'b0, 1, 0, 3, 0, WORD, 1'b0, 32'h0, fw, fv);
        tests_run++; if (fw !== model_word(1, 0, 3)) begin tests_failed++; $display("FAIL other_way got %h want %h", fw, model_word(1, 0, 3)); end
        do_cpu(1'b0, 1, 1, 2, 0, WORD, 1'b0, 32'h0, fw, fv);
        tests_run++; if (fw !== model_word(1, 1, 2)) begin tests_failed++; $display("FAIL other_word got %h want %h", fw, model_word(1, 1, 2)); end
        // Undefined size store must not write.
        do_cpu(1'b1, 1, 1, 3, 0, memory_operation_size_e'(2'b11), 1'b0, 32'h1234_5678, fw, fv);
        do_cpu(1'b0, 1, 1, 3, 0, WORD, 1'b0, 32'h0, fw, fv);
        tests_run++; if (fw !== 32'hDE80BEEF) begin tests_failed++; $display("FAIL undef_store got %h want de80beef", fw); end
    endtask

    task automatic test_random_cpu();
        logic [31:0] fw, d, exp;
        logic fv, wr, sgn;
        int s, w, wd, bs, r;
        memory_operation_size_e op;
        for (int i = 0; i < 300; i++) begin
            s = $urandom_range(0, 3); w = $urandom_range(0, 1);
            wd = $urandom_range(0, 7); bs = $urandom_range(0, 3);
            r = $urandom_range(0, 9); d = $urandom;
            wr = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
            op = (r < 3) ? BYTE : (r < 6) ? HALF : (r < 9) ? WORD : memory_operation_size_e'(2'b11);
            if (wr) begin
                do_cpu(1'b1, s, w, wd, bs, op, sgn, d, fw, fv);
                model_store(s, w, wd, bs, op, d);
            end else begin
                if (r == 9) op = WORD;
                exp = model_load(s, w, wd, bs, op, sgn);
                do_cpu(1'b0, s, w, wd, bs, op, sgn, 32'h0, fw, fv);
                tests_run++;
                if (fw !== exp || fv !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rand_load s%0d w%0d wd%0d bs%0d op%0d sgn%b got %h/%b want %h/1",
                             s, w, wd, bs, op, sgn, fw, fv, exp);
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] d [8];
        int sk [8];
        int rc, dp;
        logic df, cr, fv;
        logic [31:0] fw;
        for (int i = 0; i < 8; i++) begin d[i] = 32'h100 + 32'(i); sk[i] = (i == 3 || i == 5) ? 1 : 0; end
        fill_line(2, 0, d, sk, rc, dp, df, cr);
        for (int i = 0; i < 8; i++) model_store(2, 0, i, 0, WORD, d[i]);
        tests_run++; if (rc !== 10) begin tests_failed++; $display("FAIL fill_ready_cycles got %0d want 10", rc); end
        tests_run++; if (dp !== 1) begin tests_failed++; $display("FAIL fill_done_pulses got %0d want 1", dp); end
        tests_run++; if (df !== 1'b1) begin tests_failed++; $display("FAIL fill_done_timing got %b want 1", df); end
        tests_run++; if (cr !== 1'b1) begin tests_failed++; $display("FAIL fill_cpu_ready got %b want 1", cr); end
        for (int i = 0; i < 8; i++) begin
            do_cpu(1'b0, 2, 0, i, 0, WORD, 1'b0, 32'h0, fw, fv);
            tests_run++;
            if (fw !== 32'h100 + 32'(i)) begin tests_failed++; $display("FAIL fill_word%0d got %h want %h", i, fw, 32'h100 + 32'(i)); end
        end
    endtask

    task automatic test_evict();
        logic [31:0] got [8];
        int se, le, cy;
        logic to;
        evict_line(2, 0, 1, got, se, le, cy, to);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (got[i] !== 32'h100 + 32'(i)) begin tests_failed++; $display("FAIL evict_beat%0d got %h want %h", i, got[i], 32'h100 + 32'(i)); end
        end
        tests_run++; if (se !== 0 || le !== 0 || to !== 1'b0) begin tests_failed++; $display("FAIL evict_handshake got stable_err %0d last_err %0d timeout %b want 0 0 0", se, le, to); end
        tests_run++; if (busy !== 1'b0 || evict_valid !== 1'b0) begin tests_failed++; $display("FAIL evict_end got busy %b valid %b want 0 0", busy, evict_valid); end
    endtask

    task automatic test_simultaneous_start();
        logic [31:0] fw;
        logic fv;
        int beats = 0;
        fill_start = 1'b1; fill_set = 2'd1; fill_way = 1'b0;
        evict_start = 1'b1; evict_set = 2'd3; evict_way = 1'b0;
        cpu_req = 1'b1; cpu_write = 1'b1; set = 2'd0; selected_way = 1'b1; word_select = 3'd5;
        op_size = WORD; word_to_store = 32'hBAD0_BAD0;
        #1;
        tests_run++; if (cpu_ready !== 1'b0) begin tests_failed++; $display("FAIL collide_cpu_ready got %b want 0", cpu_ready); end
        @(negedge clk);
        fill_start = 1'b0; evict_start = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0;
        tests_run++; if (fill_ready !== 1'b0 || evict_valid !== 1'b1) begin tests_failed++; $display("FAIL collide_state got fill_ready %b evict_valid %b want 0 1", fill_ready, evict_valid); end
        evict_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if (evict_valid !== 1'b1 || evict_data !== model_word(3, 0, i)) begin
                tests_failed++;
                $display("FAIL collide_evict%0d got %b/%h want 1/%h", i, evict_valid, evict_data, model_word(3, 0, i));
            end
            if (evict_valid) beats++;
            @(negedge clk);
        end
        evict_ready = 1'b0;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || fill_ready !== 1'b0) begin tests_failed++; $display("FAIL collide_fill_ignored got busy %b fill_ready %b want 0 0", busy, fill_ready); end
        do_cpu(1'b0, 0, 1, 5, 0, WORD, 1'b0, 32'h0, fw, fv);
        tests_run++; if (fw !== model_word(0, 1, 5)) begin tests_failed++; $display("FAIL collide_no_write got %h want %h", fw, model_word(0, 1, 5)); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d [8];
        logic [31:0] fw;
        logic fv;
        int done_seen = 0;
        for (int i = 0; i < 8; i++) d[i] = $urandom;
        fill_start = 1'b1; fill_set = 2'd3; fill_way = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fill_valid = 1'b1; fill_data = d[i];
            @(negedge clk);
        end
        fill_valid = 1'b0;
        reset = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0 || fill_ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_outputs got busy %b fill_ready %b want 0 0", busy, fill_ready); end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) reset = 1'b0;
            if (fill_done) done_seen++;
            @(negedge clk);
        end
        tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL midreset_fill_done got %0d pulses want 0", done_seen); end
        for (int i = 0; i < 4; i++) model_store(3, 1, i, 0, WORD, d[i]);
        for (int i = 0; i < 8; i++) begin
            do_cpu(1'b0, 3, 1, i, 0, WORD, 1'b0, 32'h0, fw, fv);
            tests_run++;
            if (fw !== model_word(3, 1, i)) begin tests_failed++; $display("FAIL midreset_word%0d got %h want %h", i, fw, model_word(3, 1, i)); end
        end
    endtask

    task automatic test_random_bursts();
        logic [31:0] d [8];
        logic [31:0] got [8];
        int sk [8];
        int rc, dp, se, le, cy, sum, s, w;
        logic df, cr, to;
        for (int it = 0; it < 6; it++) begin
            s = $urandom_range(0, 3); w = $urandom_range(0, 1); sum = 0;
            for (int i = 0; i < 8; i++) begin d[i] = $urandom; sk[i] = $urandom_range(0, 2); sum += sk[i]; end
            fill_line(s, w, d, sk, rc, dp, df, cr);
            for (int i = 0; i < 8; i++) model_store(s, w, i, 0, WORD, d[i]);
            tests_run++;
            if (rc !== 8 + sum || dp !== 1) begin tests_failed++; $display("FAIL rfill%0d got ready %0d done %0d want %0d 1", it, rc, dp, 8 + sum); end
            s = $urandom_range(0, 3); w = $urandom_range(0, 1);
            evict_line(s, w, (it % 2 == 0) ? 0 : 2, got, se, le, cy, to);
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (got[i] !== model_word(s, w, i)) begin tests_failed++; $display("FAIL revict%0d_beat%0d got %h want %h", it, i, got[i], model_word(s, w, i)); end
            end
            tests_run++;
            if (se !== 0 || le !== 0 || to !== 1'b0) begin tests_failed++; $display("FAIL revict%0d_handshake got %0d %0d %b want 0 0 0", it, se, le, to); end
            if (it % 2 == 0) begin
                tests_run++;
                if (cy !== 8) begin tests_failed++; $display("FAIL revict%0d_rate got %0d cycles want 8", it, cy); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_array();
        test_store_load();
        test_random_cpu();
        test_fill();
        test_evict();
        test_simultaneous_start();
        test_reset_mid_fill();
        test_random_bursts();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
